// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// defaults and PC arithmetic helpers.
package if_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } if_state_e;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;

  // Branch targets from ID may carry stray low bits; fetches are word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer: parks an instruction (and its pc+4) that returned
// from memory while ID was stalled.
module if_skid_buf
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] wpc,
  output logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc,
  output logic            full
);

  // NOTE: the payload registers are reset along with the flag so no X can
  // ever leak into IF/ID, even though the flag alone marks validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      pc   <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= wdata;
      pc   <= wpc;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction-memory handshake and the
// IF/ID register. Optional perf counters are enabled by IF_PERF_CNT_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic        valid_id_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  if_state_e   state, state_next;
  logic [31:0] pc, pend_pc, pc_inc, target;
  logic        rsp_done, take, load_valid;
  logic        skid_load, skid_clear, skid_full;
  logic [31:0] skid_data, skid_pc;

  assign pc_inc   = pc + PC_INC;
  assign target   = align_pc(redirect_pc_i);
  assign rsp_done = imem_req_o && imem_ready_i;
  // A response is only useful in S_REQ and when not overridden by a redirect.
  assign take       = (state == S_REQ) && imem_ready_i && !redirect_i;
  assign skid_load  = take && stall_i;
  assign skid_clear = redirect_i || ((state == S_HOLD) && !stall_i);
  assign load_valid = !redirect_i && !stall_i && (take || (state == S_HOLD));

  assign imem_addr_o = pc;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (redirect_i && !imem_ready_i)                 state_next = S_DROP;
        else if (imem_ready_i && !redirect_i && stall_i) state_next = S_HOLD;
      end
      S_DROP: if (imem_ready_i)             state_next = S_REQ;
      S_HOLD: if (redirect_i || !stall_i)   state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: a request is outstanding in S_REQ and S_DROP.
  always_comb begin
    imem_req_o = (state == S_REQ) || (state == S_DROP);
  end

  // Fetch PC and pending redirect target. The address only moves once the
  // outstanding request completes, keeping imem_addr_o stable meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
    end else if (redirect_i) begin
      if (imem_req_o && !imem_ready_i) pend_pc <= target;
      else                             pc      <= target;
    end else if (rsp_done) begin
      pc <= (state == S_DROP) ? pend_pc : pc_inc;
    end
  end

  // IF/ID register: redirect squashes, stall holds, otherwise load a fresh
  // response, drain the skid buffer, or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_id_o <= NOP_INSTR;
      pc_id_o    <= '0;
      valid_id_o <= 1'b0;
    end else if (redirect_i) begin
      instr_id_o <= NOP_INSTR;
      valid_id_o <= 1'b0;
    end else if (!stall_i) begin
      if (take) begin
        instr_id_o <= imem_rdata_i;
        pc_id_o    <= pc_inc;
        valid_id_o <= 1'b1;
      end else if (state == S_HOLD) begin
        instr_id_o <= skid_data;
        pc_id_o    <= skid_pc;
        valid_id_o <= skid_full;
      end else begin
        instr_id_o <= NOP_INSTR;
        valid_id_o <= 1'b0;
      end
    end
  end

  if_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .wdata (imem_rdata_i),
    .wpc   (pc_inc),
    .data  (skid_data),
    .pc    (skid_pc),
    .full  (skid_full)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (load_valid)  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (!valid_id_o) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset corner
// sequence, and randomized traffic against a queue-based reference model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0, imem_ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic        imem_req_o, valid_id_o;
  logic [31:0] imem_addr_o, instr_id_o, pc_id_o;

  int n_cmp = 0;
  int n_fail = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_id_o    (instr_id_o),
    .pc_id_o       (pc_id_o),
    .valid_id_o    (valid_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr, instr, pcid;
    logic        valid;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } skid_t;

  vec_t vecs[$];

  // Reference model: fetch pointer, outstanding/discard flags, skid queue.
  logic [31:0] m_pc, m_pend, m_instr, m_pcid;
  logic        m_busy, m_discard, m_valid;
  skid_t       m_skid[$];

  function automatic vec_t v(input logic st, rd, input logic [31:0] rpc,
                             input logic rdy, input logic [31:0] data,
                             input logic req, input logic [31:0] addr, instr, pcid,
                             input logic valid);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.data = data;
    r.req = req; r.addr = addr; r.instr = instr; r.pcid = pcid; r.valid = valid;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] instr, pcid, input logic valid);
    check({tag, " req"},   {31'd0, imem_req_o}, {31'd0, req});
    check({tag, " addr"},  imem_addr_o, addr);
    check({tag, " instr"}, instr_id_o, instr);
    check({tag, " pc_id"}, pc_id_o, pcid);
    check({tag, " valid"}, {31'd0, valid_id_o}, {31'd0, valid});
  endtask

  task automatic step(input logic st, rd, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] data);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    imem_ready_i = rdy; imem_rdata_i = data;
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_busy = 1'b0; m_discard = 1'b0;
    m_instr = NOP; m_pcid = 32'h0; m_valid = 1'b0;
    m_skid.delete();
  endtask

  task automatic model_step(input logic st, rd, input logic [31:0] rpc,
                            input logic rdy, input logic [31:0] data);
    logic [31:0] tgt;
    bit done, useful, had_skid;
    skid_t e;
    tgt      = {rpc[31:2], 2'b00};
    done     = m_busy && rdy;
    useful   = done && !m_discard && !rd;
    had_skid = (m_skid.size() != 0);
    if (rd) begin
      m_instr = NOP; m_valid = 1'b0; m_skid.delete();
    end else if (st) begin
      if (useful) m_skid.push_back('{data, m_pc + 32'd4});
    end else if (useful) begin
      m_instr = data; m_pcid = m_pc + 32'd4; m_valid = 1'b1;
    end else if (had_skid) begin
      e = m_skid.pop_front();
      m_instr = e.instr; m_pcid = e.pc; m_valid = 1'b1;
    end else begin
      m_instr = NOP; m_valid = 1'b0;
    end
    if (rd) begin
      if (m_busy && !rdy) begin
        m_pend = tgt; m_discard = 1'b1;
      end else begin
        m_pc = tgt; m_busy = 1'b1; m_discard = 1'b0;
      end
    end else if (m_busy) begin
      if (rdy) begin
        if (m_discard) begin
          m_pc = m_pend; m_discard = 1'b0;
        end else begin
          m_pc = m_pc + 32'd4;
          if (st) m_busy = 1'b0;
        end
      end
    end else if (!(had_skid && st)) begin
      m_busy = 1'b1;
    end
  endtask

  initial begin
    // Directed table: after reset release, sequential fetch, wait states,
    // stall into skid, redirects (latest wins, alignment), wrap-around.
    vecs.push_back(v(0,0,32'h0,       0,32'h0,       1,32'h0,       NOP,          32'h0,  0));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000000,1,32'h4,       32'h10000000, 32'h4,  1));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000004,1,32'h8,       32'h10000004, 32'h8,  1));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000008,1,32'hC,       32'h10000008, 32'hC,  1));
    vecs.push_back(v(0,0,32'h0,       1,32'h1000000C,1,32'h10,      32'h1000000C, 32'h10, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0,0,32'h0,     0,32'h0,       1,32'h10,      NOP,          32'h10, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000010,1,32'h14,      32'h10000010, 32'h14, 1));
    vecs.push_back(v(1,0,32'h0,       1,32'hAAAA0001,0,32'h18,      32'h10000010, 32'h14, 1));
    vecs.push_back(v(1,0,32'h0,       0,32'h0,       0,32'h18,      32'h10000010, 32'h14, 1));
    vecs.push_back(v(0,0,32'h0,       0,32'h0,       1,32'h18,      32'hAAAA0001, 32'h18, 1));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000018,1,32'h1C,      32'h10000018, 32'h1C, 1));
    vecs.push_back(v(0,0,32'h0,       1,32'h1000001C,1,32'h20,      32'h1000001C, 32'h20, 1));
    vecs.push_back(v(0,1,32'h40,      0,32'h0,       1,32'h20,      NOP,          32'h20, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'hDEAD0020,1,32'h40,      NOP,          32'h20, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000040,1,32'h44,      32'h10000040, 32'h44, 1));
    vecs.push_back(v(0,1,32'h100,     0,32'h0,       1,32'h44,      NOP,          32'h44, 0));
    vecs.push_back(v(0,1,32'h83,      0,32'h0,       1,32'h44,      NOP,          32'h44, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'hDEAD0044,1,32'h80,      NOP,          32'h44, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000080,1,32'h84,      32'h10000080, 32'h84, 1));
    vecs.push_back(v(1,0,32'h0,       1,32'hBBBB0084,0,32'h88,      32'h10000080, 32'h84, 1));
    vecs.push_back(v(1,1,32'h200,     0,32'h0,       1,32'h200,     NOP,          32'h84, 0));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000200,1,32'h204,     32'h10000200, 32'h204,1));
    vecs.push_back(v(0,1,32'hFFFFFFFC,1,32'hDEAD0204,1,32'hFFFFFFFC,NOP,          32'h204,0));
    vecs.push_back(v(0,0,32'h0,       1,32'h1000FFFC,1,32'h0,       32'h1000FFFC, 32'h0,  1));
    vecs.push_back(v(0,0,32'h0,       1,32'h10000000,1,32'h4,       32'h10000000, 32'h4,  1));
    vecs.push_back(v(0,0,32'h0,       0,32'h0,       1,32'h4,       NOP,          32'h4,  0));

    #12;
    check_out("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("idle_after_reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].data);
      check_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                vecs[i].instr, vecs[i].pcid, vecs[i].valid);
    end

    // Reset with a request outstanding: outputs drop immediately, and a late
    // ready in the first idle cycle is ignored.
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    step(0, 0, 32'h0, 1, 32'hDEADBEEF);
    check_out("held_in_reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 32'h0, 1, 32'hDEADBEEF);
    check_out("late_ready_ignored", 1'b1, 32'h0, NOP, 32'h0, 1'b0);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_out("rand_reset", m_busy, m_pc, m_instr, m_pcid, m_valid);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic st, rd, rdy;
      logic [31:0] rpc, data;
      st   = ($urandom_range(99) < 25);
      rd   = ($urandom_range(99) < 8);
      rdy  = m_busy && ($urandom_range(99) < 60);
      rpc  = $urandom;
      data = $urandom;
      step(st, rd, rpc, rdy, data);
      model_step(st, rd, rpc, rdy, data);
      check_out($sformatf("rand%0d", c), m_busy, m_pc, m_instr, m_pcid, m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0000, instruction presented to ID for a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall_i  in  1  ID cannot accept; hold IF/ID outputs.
REQ-006 redirect_i  in  1  taken branch/jump from ID.
REQ-007 redirect_pc_i  in  32  branch target from ID.
REQ-008 imem_req_o  out  1  fetch request to instruction memory.
REQ-009 imem_addr_o  out  32  fetch address, word aligned.
REQ-010 imem_ready_i  in  1  imem_rdata_i valid; completes current request.
REQ-011 imem_rdata_i  in  32  fetched instruction.
REQ-012 instr_id_o  out  32  IF/ID instruction register, feeds ID instruction input.
REQ-013 pc_id_o  out  32  fetch address + 4, feeds ID pcIn_ID for branch-target arithmetic.
REQ-014 valid_id_o  out  1  instr_id_o holds a real instruction.

Function
REQ-015 SHALL implement FSM states S_IDLE (req low), S_REQ (req high), S_DROP (req high, response to be discarded), S_HOLD (skid full, req low).
REQ-016 SHALL hold imem_addr_o stable while imem_req_o is high until imem_ready_i is sampled high.
REQ-017 S_REQ and ready and !stall_i and !redirect_i: load instr_id_o=rdata, pc_id_o=pc+4, valid=1; pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0); stay S_REQ.
REQ-018 S_REQ and ready and stall_i and !redirect_i: IF/ID unchanged; rdata and pc+4 written to one-entry skid buffer; pc<=pc+4; go S_HOLD.
REQ-019 S_HOLD and !stall_i: skid moved to IF/ID with valid=1; go S_REQ next cycle.
REQ-020 S_REQ and !ready and redirect_i: pending target latched; go S_DROP; IF/ID loaded with bubble unless stall_i.
REQ-021 S_DROP and ready: response discarded; pc<=pending target; go S_REQ.
REQ-022 Any state, ready and redirect_i in same cycle: response discarded; pc<=redirect_pc_i; go S_REQ.
REQ-023 redirect_i SHALL take priority over stall_i: IF/ID loaded with instr=NOP_INSTR, valid=0; skid buffer cleared.
REQ-024 Redirect in S_DROP SHALL overwrite pending target (latest wins).
REQ-025 Redirect in S_IDLE or S_HOLD SHALL set pc<=redirect_pc_i and go S_REQ.
REQ-026 redirect_pc_i[1:0] SHALL be forced to 00 when loaded.
REQ-027 Fetch-to-ID latency SHALL be 1 cycle after the ready cycle with no stall.
REQ-028 While stall_i and no redirect, instr_id_o/pc_id_o/valid_id_o SHALL not change.

Reset
REQ-029 rst_n low SHALL asynchronously set pc=RESET_PC, state=S_IDLE, imem_req_o=0, instr_id_o=NOP_INSTR, pc_id_o=0, valid_id_o=0, skid empty, pending target=0.
REQ-030 First cycle after rst_n release SHALL stay S_IDLE; S_REQ with imem_addr_o=RESET_PC follows.
REQ-031 Reset asserted with a request outstanding SHALL abandon it; late ready ignored in S_IDLE.

Configuration
REQ-032 With IF_PERF_CNT_EN defined: outputs fetch_cnt_o[31:0] (increments on each instruction loaded into IF/ID with valid=1) and bubble_cnt_o[31:0] (increments on each cycle valid_id_o=0 after reset), both reset to 0, wrapping.
REQ-033 Without IF_PERF_CNT_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-034 Shared package if_pkg SHALL hold FSM state encoding, NOP_INSTR default, RESET_PC default, PC_INC=4.
REQ-035 Skid buffer SHALL be sub-module if_skid_buf (one entry: data, pc, full flag); remainder flat.

Verification
REQ-036 Reset release, ready=1 every cycle -> addresses 0,4,8; instr_id_o follows rdata one cycle later; pc_id_o=4,8,12.
REQ-037 ready delayed 3 cycles at addr 0x10 -> imem_addr_o stays 0x10, valid_id_o=0 those cycles, then instr with pc_id_o=0x14.
REQ-038 stall_i high on ready cycle (rdata 0xAAAA0001) -> IF/ID unchanged, req low; stall drop -> instr_id_o=0xAAAA0001, next addr = old+4.
REQ-039 redirect_i to 0x40 while request to 0x20 pending -> 0x20 response discarded, next imem_addr_o=0x40, valid_id_o=0 for bubble.
REQ-040 redirect_i and stall_i together with skid full -> skid cleared, instr_id_o=NOP_INSTR, valid=0, next fetch at target.
REQ-041 PC at 0xFFFF_FFFC fetched -> next imem_addr_o=0x0000_0000; rst_n low mid-request -> outputs per REQ-029 immediately.
